// File: rtl/mdu_controller.sv
// -----------------------------------------------------------------------------
// mdu_controller
//
// Sequencing controller between the CPU execute stage and the multiply/divide
// unit. It accepts one request at a time, latches the operands and holds them
// stable on the MDU inputs. It stalls the pipeline while an operation is in
// flight and returns a one-cycle response carrying the result and destination.
// A divide by zero is answered locally with an all-ones quotient. iFlush kills
// the in-flight operation.
//
// Ports:
//   iClk, iRst_n           clock (rising edge), asynchronous active-low reset
//   iReqValid/iReqOp       request strobe, operation (0 = mul, 1 = div)
//   iReqSrc0/iReqSrc1      multiplicand/dividend, multiplier/divisor
//   iReqDest               destination register index
//   iFlush                 kill the in-flight operation, block acceptance
//   iMduResult             result output of the MDU
//   oReqReady, oStall      handshake back to the execute stage
//   oBusy                  an operation is in flight
//   oMduSrc0/1, oMduOperation  registered operands and op select to the MDU
//   oRspValid/oRspResult/oRspDest  one-cycle response
// -----------------------------------------------------------------------------
module mdu_controller #(
    parameter int WIDTH       = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int DIV_LATENCY = 36,
    parameter int DIV_CNT_W   = 6
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iReqValid,
    input  logic                  iReqOp,
    input  logic [WIDTH-1:0]      iReqSrc0,
    input  logic [WIDTH-1:0]      iReqSrc1,
    input  logic [REG_ADDR_W-1:0] iReqDest,
    input  logic                  iFlush,
    input  logic [WIDTH-1:0]      iMduResult,
    output logic                  oReqReady,
    output logic                  oStall,
    output logic                  oBusy,
    output logic [WIDTH-1:0]      oMduSrc0,
    output logic [WIDTH-1:0]      oMduSrc1,
    output logic                  oMduOperation,
    output logic                  oRspValid,
    output logic [WIDTH-1:0]      oRspResult,
    output logic [REG_ADDR_W-1:0] oRspDest
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               stateReg;
    state_t               stateNext;
    logic [DIV_CNT_W-1:0] cntReg;
    logic                 accept;
    logic                 divByZero;

    assign oReqReady = (stateReg == IDLE) && !iFlush;
    assign accept    = iReqValid && oReqReady;
    assign oStall    = iReqValid && !oReqReady;
    assign oBusy     = (stateReg != IDLE);
    assign oRspValid = (stateReg == DONE) && !iFlush;
    assign divByZero = (iReqSrc1 == '0);

    // State register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    if (!iReqOp)        stateNext = MUL_WAIT;
                    else if (divByZero) stateNext = DONE;
                    else                stateNext = DIV_WAIT;
                end
            end
            MUL_WAIT: stateNext = iFlush ? IDLE : DONE;
            DIV_WAIT: begin
                if (iFlush)                          stateNext = IDLE;
                else if (cntReg == DIV_CNT_W'(1))    stateNext = DONE;
                else                                 stateNext = DIV_WAIT;
            end
            DONE:     stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // Operand latch, divide counter and result capture. The MDU operands are
    // only ever written on accept, so they stay put for the whole operation.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cntReg        <= '0;
            oMduSrc0      <= '0;
            oMduSrc1      <= '0;
            oMduOperation <= 1'b0;
            oRspResult    <= '0;
            oRspDest      <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (accept) begin
                        oMduSrc0      <= iReqSrc0;
                        oMduSrc1      <= iReqSrc1;
                        oMduOperation <= iReqOp;
                        oRspDest      <= iReqDest;
                        if (iReqOp && divByZero) begin
                            // Answered locally; the divider is never waited on.
                            oRspResult <= '1;
                        end else if (iReqOp) begin
                            cntReg <= DIV_CNT_W'(DIV_LATENCY);
                        end
                    end
                end
                MUL_WAIT: begin
                    if (!iFlush) begin
                        oRspResult <= iMduResult;
                    end
                end
                DIV_WAIT: begin
                    if (iFlush) begin
                        cntReg <= '0;
                    end else if (cntReg == DIV_CNT_W'(1)) begin
                        oRspResult <= iMduResult;
                        cntReg     <= '0;
                    end else begin
                        cntReg <= cntReg - DIV_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_controller.sv
// -----------------------------------------------------------------------------
// tb_mdu_controller
//
// Table-driven bench for mdu_controller with a behavioural MDU (unsigned
// truncated product / unsigned quotient) and hand-written sequences for flush,
// flush in DONE and reset in the middle of a divide. Inputs are driven and
// outputs sampled on the falling edge of iClk.
// -----------------------------------------------------------------------------
module tb_mdu_controller;

    localparam int WIDTH       = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int DIV_LATENCY = 36;
    localparam int DIV_CNT_W   = 6;

    logic                  iClk = 1'b0;
    logic                  iRst_n;
    logic                  iReqValid;
    logic                  iReqOp;
    logic [WIDTH-1:0]      iReqSrc0;
    logic [WIDTH-1:0]      iReqSrc1;
    logic [REG_ADDR_W-1:0] iReqDest;
    logic                  iFlush;
    logic [WIDTH-1:0]      iMduResult;
    logic                  oReqReady;
    logic                  oStall;
    logic                  oBusy;
    logic [WIDTH-1:0]      oMduSrc0;
    logic [WIDTH-1:0]      oMduSrc1;
    logic                  oMduOperation;
    logic                  oRspValid;
    logic [WIDTH-1:0]      oRspResult;
    logic [REG_ADDR_W-1:0] oRspDest;

    int nChecks = 0;
    int nFails  = 0;

    always #5 iClk = ~iClk;

    mdu_controller #(
        .WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W),
        .DIV_LATENCY(DIV_LATENCY), .DIV_CNT_W(DIV_CNT_W)
    ) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iReqValid(iReqValid), .iReqOp(iReqOp),
        .iReqSrc0(iReqSrc0), .iReqSrc1(iReqSrc1), .iReqDest(iReqDest),
        .iFlush(iFlush), .iMduResult(iMduResult),
        .oReqReady(oReqReady), .oStall(oStall), .oBusy(oBusy),
        .oMduSrc0(oMduSrc0), .oMduSrc1(oMduSrc1), .oMduOperation(oMduOperation),
        .oRspValid(oRspValid), .oRspResult(oRspResult), .oRspDest(oRspDest)
    );

    // Behavioural MDU driven from the controller's registered operands.
    logic [WIDTH-1:0] product;
    always_comb begin
        product = oMduSrc0 * oMduSrc1;
        if (!oMduOperation)        iMduResult = product;
        else if (oMduSrc1 == '0)   iMduResult = '1;
        else                       iMduResult = oMduSrc0 / oMduSrc1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic                  op;
        logic [WIDTH-1:0]      src0;
        logic [WIDTH-1:0]      src1;
        logic [REG_ADDR_W-1:0] dest;
        logic                  hold;     // keep iReqValid high while busy
        logic [WIDTH-1:0]      expRes;
        int                    expLat;   // cycles from accept cycle to oRspValid
    } vec_t;

    vec_t vecs [7];

    // Issue one request and follow it to its response.
    task automatic runOp(input vec_t v);
        int  lat;
        bit  stable;
        bit  stallOk;
        @(negedge iClk);
        iReqValid = 1'b1; iReqOp = v.op; iReqSrc0 = v.src0; iReqSrc1 = v.src1;
        iReqDest = v.dest;
        #1;
        check("accept_ready", {31'd0, oReqReady}, 32'd1);
        lat = 0; stable = 1'b1; stallOk = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge iClk);
            iReqValid = v.hold;
            iReqSrc0 = ~v.src0; iReqSrc1 = ~v.src1; iReqDest = ~v.dest;
            #1;
            if (oMduSrc0 !== v.src0 || oMduSrc1 !== v.src1 || oMduOperation !== v.op)
                stable = 1'b0;
            if (v.hold && oStall !== 1'b1) stallOk = 1'b0;
            if (oRspValid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("rsp_latency", lat, v.expLat);
        check("rsp_result", oRspResult, v.expRes);
        check("rsp_dest", {27'd0, oRspDest}, {27'd0, v.dest});
        check("operands_stable", {31'd0, stable}, 32'd1);
        if (v.hold) check("stall_held", {31'd0, stallOk}, 32'd1);
        $display("txn op=%0d src0=%h src1=%h dest=%0d -> result=%h dest=%0d latency=%0d",
                 v.op, v.src0, v.src1, v.dest, oRspResult, oRspDest, lat);
        @(negedge iClk);
        iReqValid = 1'b0;
        #1;
        check("post_rsp_valid", {31'd0, oRspValid}, 32'd0);
        check("post_rsp_ready", {31'd0, oReqReady}, 32'd1);
    endtask

    // Watch for a stray response over n cycles.
    task automatic watchQuiet(input string name, input int n);
        bit quiet;
        quiet = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge iClk);
            #1;
            if (oRspValid !== 1'b0) quiet = 1'b0;
        end
        check(name, {31'd0, quiet}, 32'd1);
    endtask

    initial begin
        vec_t m;
        vecs[0] = '{1'b0, 32'd7, 32'd6, 5'd5, 1'b0, 32'd42, 2};
        vecs[1] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 5'd1, 1'b0, 32'd0, 2};
        vecs[2] = '{1'b1, 32'd100, 32'd7, 5'd9, 1'b1, 32'd14, DIV_LATENCY + 1};
        vecs[3] = '{1'b1, 32'd55, 32'd0, 5'd3, 1'b0, 32'hFFFF_FFFF, 1};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd2, 5'd31, 1'b0, 32'hFFFF_FFFE, 2};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'd1, 5'd17, 1'b0, 32'hFFFF_FFFF, DIV_LATENCY + 1};
        vecs[6] = '{1'b1, 32'd7, 32'd100, 5'd12, 1'b0, 32'd0, DIV_LATENCY + 1};

        iRst_n = 1'b0; iReqValid = 1'b0; iReqOp = 1'b0; iReqSrc0 = '0;
        iReqSrc1 = '0; iReqDest = '0; iFlush = 1'b0;
        #1;
        check("rst_ready", {31'd0, oReqReady}, 32'd1);
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        check("rst_stall", {31'd0, oStall}, 32'd0);
        check("rst_rsp_valid", {31'd0, oRspValid}, 32'd0);
        check("rst_mdu_src0", oMduSrc0, 32'd0);
        check("rst_mdu_src1", oMduSrc1, 32'd0);
        check("rst_mdu_op", {31'd0, oMduOperation}, 32'd0);
        check("rst_rsp_result", oRspResult, 32'd0);
        check("rst_rsp_dest", {27'd0, oRspDest}, 32'd0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;

        // Flush in IDLE blocks acceptance and stalls a valid request.
        @(negedge iClk);
        iFlush = 1'b1; iReqValid = 1'b1; iReqOp = 1'b0; iReqSrc0 = 32'd9; iReqSrc1 = 32'd9;
        #1;
        check("idle_flush_ready", {31'd0, oReqReady}, 32'd0);
        check("idle_flush_stall", {31'd0, oStall}, 32'd1);
        @(negedge iClk);
        iFlush = 1'b0; iReqValid = 1'b0;
        #1;
        check("idle_flush_no_accept", {31'd0, oBusy}, 32'd0);

        for (int i = 0; i < 7; i++) runOp(vecs[i]);

        // Flush in the 10th DIV_WAIT cycle of div 1000/3.
        @(negedge iClk);
        iReqValid = 1'b1; iReqOp = 1'b1; iReqSrc0 = 32'd1000; iReqSrc1 = 32'd3; iReqDest = 5'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge iClk);
            iReqValid = 1'b0;
            if (k == 10) iFlush = 1'b1;
        end
        #1;
        check("flush_busy_before", {31'd0, oBusy}, 32'd1);
        check("flush_rsp_valid", {31'd0, oRspValid}, 32'd0);
        @(negedge iClk);
        iFlush = 1'b0;
        #1;
        check("flush_ready_after", {31'd0, oReqReady}, 32'd1);
        check("flush_busy_after", {31'd0, oBusy}, 32'd0);
        watchQuiet("flush_no_rsp", 40);
        m = '{1'b0, 32'd3, 32'd4, 5'd2, 1'b0, 32'd12, 2};
        runOp(m);

        // Flush in the DONE cycle of mul 5*5.
        @(negedge iClk);
        iReqValid = 1'b1; iReqOp = 1'b0; iReqSrc0 = 32'd5; iReqSrc1 = 32'd5; iReqDest = 5'd4;
        @(negedge iClk);
        iReqValid = 1'b0;
        @(negedge iClk);
        iFlush = 1'b1;
        #1;
        check("done_flush_busy", {31'd0, oBusy}, 32'd1);
        check("done_flush_rsp_valid", {31'd0, oRspValid}, 32'd0);
        @(negedge iClk);
        iFlush = 1'b0;
        #1;
        check("done_flush_idle", {31'd0, oBusy}, 32'd0);
        check("done_flush_no_late_rsp", {31'd0, oRspValid}, 32'd0);

        // Reset in the middle of div 100/7.
        @(negedge iClk);
        iReqValid = 1'b1; iReqOp = 1'b1; iReqSrc0 = 32'd100; iReqSrc1 = 32'd7; iReqDest = 5'd9;
        repeat (5) begin
            @(negedge iClk);
            iReqValid = 1'b0;
        end
        #1;
        check("mid_rst_busy_before", {31'd0, oBusy}, 32'd1);
        iRst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, oBusy}, 32'd0);
        check("mid_rst_ready", {31'd0, oReqReady}, 32'd1);
        check("mid_rst_mdu_src0", oMduSrc0, 32'd0);
        check("mid_rst_mdu_src1", oMduSrc1, 32'd0);
        check("mid_rst_rsp_dest", {27'd0, oRspDest}, 32'd0);
        @(negedge iClk);
        iRst_n = 1'b1;
        watchQuiet("mid_rst_no_rsp", 40);
        m = '{1'b0, 32'd2, 32'd2, 5'd6, 1'b0, 32'd4, 2};
        runOp(m);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
